// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared definitions for the sequential shift-add multiplier:
//               FSM state encoding, default operand width and the helper
//               that sizes the iteration counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    // One extra bit so the counter can hold WIDTH itself without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_add_step.sv
`default_nettype none
// ============================================================================
// Module      : mul_add_step
// Description : One radix-2 shift-add iteration. Conditionally adds the
//               multiplicand to the upper accumulator (gated by the current
//               multiplier LSB), then shifts {sum, acc_lo} right by one.
//               Purely combinational.
// Ports       : mcand      - multiplicand (WIDTH)
//               acc_hi     - upper accumulator (WIDTH+1)
//               acc_lo     - lower accumulator / remaining multiplier (WIDTH)
//               acc_hi_nxt - updated upper accumulator (WIDTH+1)
//               acc_lo_nxt - updated lower accumulator (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH:0]   acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic [WIDTH:0]   acc_hi_nxt,
    output logic [WIDTH-1:0] acc_lo_nxt
);

    logic [WIDTH:0] w_addend;
    logic [WIDTH:0] w_sum;

    assign w_addend = acc_lo[0] ? {1'b0, mcand} : '0;
    // acc_hi never exceeds WIDTH bits after a shift, so WIDTH+1 bits hold the sum.
    assign w_sum    = acc_hi + w_addend;

    // {sum, acc_lo} >> 1 with a zero entering the MSB.
    assign acc_hi_nxt = {1'b0, w_sum[WIDTH:1]};
    assign acc_lo_nxt = {w_sum[0], acc_lo[WIDTH-1:1]};

endmodule
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Multi-cycle WIDTHxWIDTH multiply controller. Sequences a
//               radix-2 shift-add datapath, one partial product per clock,
//               with valid/ready handshakes on operand and result sides.
//               Optional signed support is enabled by defining MUL_SIGNED_EN.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - operand handshake (ready only in IDLE)
//               a, b, op_signed     - operands and signed-mode request
//               out_valid/out_ready - result handshake (held until accepted)
//               product             - 2*WIDTH result, stable while valid
//               busy                - high in RUN or DONE
// Macros      : MUL_SIGNED_EN - honour op_signed (magnitude multiply + negate)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 op_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    mul_state_t            r_state;
    mul_state_t            w_state_nxt;

    logic [WIDTH-1:0]      r_mcand;
    logic [WIDTH:0]        r_acc_hi;
    logic [WIDTH-1:0]      r_acc_lo;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*WIDTH-1:0]    r_product;

    logic                  w_accept;
    logic                  w_last;
    logic [WIDTH:0]        w_hi_nxt;
    logic [WIDTH-1:0]      w_lo_nxt;
    logic [2*WIDTH-1:0]    w_mag_product;
    logic [2*WIDTH-1:0]    w_final_product;
    logic [WIDTH-1:0]      w_load_a;
    logic [WIDTH-1:0]      w_load_b;
    logic                  w_unused_hi_msb;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    mul_add_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .mcand      (r_mcand),
        .acc_hi     (r_acc_hi),
        .acc_lo     (r_acc_lo),
        .acc_hi_nxt (w_hi_nxt),
        .acc_lo_nxt (w_lo_nxt)
    );

    // The product is taken from the step output so the final iteration and
    // the result capture happen on the same edge.
    assign w_mag_product   = {w_hi_nxt[WIDTH-1:0], w_lo_nxt};
    // Always zero after the shift; not part of the product.
    assign w_unused_hi_msb = w_hi_nxt[WIDTH];

`ifdef MUL_SIGNED_EN
    logic                  r_neg;
    logic                  w_sign_a;
    logic                  w_sign_b;

    assign w_sign_a = op_signed && a[WIDTH-1];
    assign w_sign_b = op_signed && b[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign w_load_a = w_sign_a ? (~a + WIDTH'(1)) : a;
    assign w_load_b = w_sign_b ? (~b + WIDTH'(1)) : b;
    assign w_final_product = r_neg ? (~w_mag_product + (2*WIDTH)'(1)) : w_mag_product;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_sign_a ^ w_sign_b;
        end
    end
`else
    logic                  w_unused_op_signed;

    assign w_unused_op_signed = op_signed;
    assign w_load_a           = a;
    assign w_load_b           = b;
    assign w_final_product    = w_mag_product;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= w_load_a;
            r_acc_hi <= '0;
            r_acc_lo <= w_load_b;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_acc_hi <= w_hi_nxt;
            r_acc_lo <= w_lo_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_product <= w_final_product;
            end
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Self-checking testbench for mul_seq_ctrl. Directed vectors
//               with hand-computed products plus a randomised back-to-back
//               run against a behavioural multiply model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

    localparam int W = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            op_signed;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  product;
    logic            busy;

    int checks = 0;
    int errors = 0;

    mul_seq_ctrl #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_signed (op_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one operand pair in IDLE; returns at the negedge after the accept edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
        @(negedge clk);
        a         = ta;
        b         = tb_v;
        op_signed = ts;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b prod=%h, want rdy=1 vld=0 busy=0 prod=0",
                     in_ready, out_valid, busy, product);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        start_op(32'd3, 32'd5, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_drop: got rdy=%b busy=%b, want rdy=0 busy=1", in_ready, busy);
        end
        wait_valid(lat);
        // Accept cycle is index 0; out_valid first appears in cycle index 33.
        checks++;
        if (lat + 1 !== 33) begin
            errors++;
            $display("FAIL basic_latency: got cycle %0d, want 33", lat + 1);
        end
        checks++;
        if (product !== 64'h0000_0000_0000_000F) begin
            errors++;
            $display("FAIL basic_product: got %h, want 000000000000000f", product);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return_idle: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_corners();
        logic [W-1:0]   ta [3];
        logic [W-1:0]   tbv[3];
        logic [2*W-1:0] te [3];
        int lat;
        ta[0] = 32'hFFFF_FFFF; tbv[0] = 32'hFFFF_FFFF; te[0] = 64'hFFFF_FFFE_0000_0001;
        ta[1] = 32'h0000_0000; tbv[1] = 32'h1234_5678; te[1] = 64'h0;
        ta[2] = 32'h0001_0000; tbv[2] = 32'h0001_0000; te[2] = 64'h0000_0001_0000_0000;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tbv[i], 1'b0);
            wait_valid(lat);
            checks++;
            if (lat + 1 !== 33 || product !== te[i]) begin
                errors++;
                $display("FAIL corner_%0d: got cycle %0d prod=%h, want cycle 33 prod=%h",
                         i, lat + 1, product, te[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        start_op(32'hDEAD_BEEF, 32'h0000_0010, 1'b0);
        wait_valid(lat);
        checks++;
        if (product !== 64'h0000_000D_EADB_EEF0) begin
            errors++;
            $display("FAIL bp_product: got %h, want 0000000deadbeef0", product);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 64'h0000_000D_EADB_EEF0) begin
                errors++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b prod=%h, want vld=1 rdy=0 prod=0000000deadbeef0",
                         i, out_valid, in_ready, product);
            end
        end
        // New operand offered in the same cycle as out_ready: must wait for IDLE.
        @(negedge clk);
        out_ready = 1'b1;
        a         = 32'd6;
        b         = 32'd9;
        op_signed = 1'b0;
        in_valid  = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_overlap: got rdy=%b, want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_late_accept: got busy=%b rdy=%b, want busy=1 rdy=0", busy, in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat + 1 !== 33 || product !== 64'd54) begin
            errors++;
            $display("FAIL bp_second_op: got cycle %0d prod=%h, want cycle 33 prod=36", lat + 1, product);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        start_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== '0) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b vld=%b busy=%b prod=%h, want rdy=1 vld=0 busy=0 prod=0",
                     in_ready, out_valid, busy, product);
        end
        start_op(32'd7, 32'd6, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat + 1 !== 33 || product !== 64'd42) begin
            errors++;
            $display("FAIL reset_mid_retry: got cycle %0d prod=%h, want cycle 33 prod=2a", lat + 1, product);
        end
        @(negedge clk);
    endtask

    task automatic test_signed();
        logic [W-1:0]   ta [3];
        logic [W-1:0]   tbv[3];
        logic           ts [3];
        logic [2*W-1:0] te [3];
        int lat;
        ta[0] = 32'hFFFF_FFFD; tbv[0] = 32'h0000_0007; ts[0] = 1'b1;
        ta[1] = 32'h8000_0000; tbv[1] = 32'hFFFF_FFFF; ts[1] = 1'b1;
        ta[2] = 32'hFFFF_FFFF; tbv[2] = 32'h0000_0002; ts[2] = 1'b0;
`ifdef MUL_SIGNED_EN
        te[0] = 64'hFFFF_FFFF_FFFF_FFEB;
        te[1] = 64'h0000_0000_8000_0000;
`else
        // op_signed ignored: plain unsigned products.
        te[0] = 64'h0000_0006_FFFF_FFEB;
        te[1] = 64'h7FFF_FFFF_8000_0000;
`endif
        te[2] = 64'h0000_0001_FFFF_FFFE;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tbv[i], ts[i]);
            wait_valid(lat);
            checks++;
            if (lat + 1 !== 33 || product !== te[i]) begin
                errors++;
                $display("FAIL signed_%0d: got cycle %0d prod=%h, want cycle 33 prod=%h",
                         i, lat + 1, product, te[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]          ra, rb;
        logic                  rs;
        logic                  use_signed;
        logic signed [2*W-1:0] sa, sb;
        logic [2*W-1:0]        expv;
        int                    cyc;
        bit                    done;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_idle_%0d: got rdy=%b, want 1", i, in_ready);
            end
            ra = $urandom();
            rb = $urandom();
            rs = 1'($urandom_range(0, 1));
            a = ra; b = rb; op_signed = rs; in_valid = 1'b1;
`ifdef MUL_SIGNED_EN
            use_signed = rs;
`else
            use_signed = 1'b0;
`endif
            if (use_signed) begin
                sa   = {{W{ra[W-1]}}, ra};
                sb   = {{W{rb[W-1]}}, rb};
                expv = sa * sb;
            end else begin
                expv = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            end
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 200) begin
                @(negedge clk);
                cyc++;
                // Garbage on the operand port while busy must be ignored.
                in_valid  = 1'($urandom_range(0, 1));
                a         = $urandom();
                b         = $urandom();
                op_signed = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    done = 1'b1;
                    checks++;
                    if (product !== expv) begin
                        errors++;
                        $display("FAIL b2b_product_%0d: a=%h b=%h s=%b got %h, want %h",
                                 i, ra, rb, rs, product, expv);
                    end
                end
            end
            if (!done) begin
                errors++;
                $display("FAIL b2b_timeout_%0d: no result within 200 cycles", i);
                return;
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_single_%0d: got vld=%b rdy=%b, want vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op_signed = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_signed();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle 32x32 multiply controller. It sequences a radix-2 shift-add datapath, one partial product per clock, and is the low-area alternative to the full combinational carry-save array multiplier.
- Sits between the ALU issue logic and the writeback path.
- Valid/ready handshake on both the operand side and the result side.
- Produces a 64-bit product.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b (and op_signed) are valid.
- in_ready  out  1  controller can accept operands; high only in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- op_signed  in  1  treat a and b as two's complement; honoured only when MUL_SIGNED_EN is defined.
- out_valid  out  1  product is valid; held until accepted.
- out_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  result; stable while out_valid is high.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clock edge): state to IDLE, counter to 0, accumulator to 0. Outputs: in_ready=1, out_valid=0, busy=0, product=0. An operation in flight is abandoned; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a into mcand, load acc_hi=0 (WIDTH+1 bits) and acc_lo=b, counter=0, go to RUN.
- RUN, one iteration per cycle:
  - sum = acc_hi + (acc_lo[0] ? mcand : 0), computed at WIDTH+1 bits.
  - Then {acc_hi,acc_lo} = {sum,acc_lo} >> 1, with a zero shifted into the MSB.
  - Counter increments each cycle. When counter == WIDTH-1, go to DONE and register product={acc_hi[WIDTH-1:0],acc_lo}.
- DONE:
  - out_valid=1.
  - On out_ready, go to IDLE (out_valid drops the next cycle).
  - Without out_ready, hold: product and out_valid stay unchanged indefinitely.
- Latency:
  - Accept in cycle 0; RUN occupies cycles 1..WIDTH; out_valid first high in cycle WIDTH+1 (33 for the default).
  - Throughput is one op per WIDTH+2 cycles minimum.
  - No overlap: in_ready stays 0 until DONE completes. A new operand presented in the same cycle as out_ready is accepted only in the following IDLE cycle.
- Arithmetic: all unsigned; the product never overflows 2*WIDTH bits.
- Boundary cases:
  - a=0 or b=0 still takes the full WIDTH iterations; there is no early termination.
  - The counter never wraps: it is cleared on acceptance.
- Inputs a, b and op_signed are ignored outside the accept cycle.

Optional Feature:
- MUL_SIGNED_EN defined:
  - At accept with op_signed=1, the magnitudes |a| and |b| are loaded, and neg = a[MSB]^b[MSB] is stored.
  - On entry to DONE, product is the two's-complement negation of the magnitude product when neg=1.
  - Latency is unchanged.
  - -2^(WIDTH-1) operands are handled: the magnitude fits as unsigned WIDTH bits.
- MUL_SIGNED_EN undefined:
  - op_signed is ignored; all operations are unsigned.
  - No negation logic is synthesised.

Decomposition:
- Shared package mul_pkg:
  - State enum mul_state_t {IDLE, RUN, DONE}.
  - Localparam MUL_WIDTH=32.
  - Function for the CNT_W computation.
- Sub-module mul_add_step: purely combinational WIDTH+1-bit conditional add plus 1-bit right shift of {acc_hi,acc_lo}. Instantiated once inside mul_seq_ctrl; the FSM, counter and registers stay in the top.

Test Plan:
- a=3, b=5, out_ready=1: in_ready drops the cycle after acceptance; out_valid rises exactly 33 cycles after the accept edge with product=0x000000000000000F; in_ready returns 1 one cycle later.
- a=0xFFFFFFFF, b=0xFFFFFFFF: product=0xFFFFFFFE00000001; a=0, b=0x12345678: product=0 after the full 33-cycle latency.
- Back-pressure: out_ready=0 for 10 cycles after out_valid → product and out_valid held constant and in_ready stays 0; raise out_ready → out_valid low the next cycle.
- Reset mid-operation: rst=1 at RUN iteration 10 → next cycle in_ready=1, out_valid=0, product=0, busy=0; a fresh 7*6 then yields 42 after 33 cycles.
- MUL_SIGNED_EN, op_signed=1:
  - a=-3, b=7 → 0xFFFFFFFFFFFFFFEB.
  - a=0x80000000, b=-1 → 0x0000000080000000.
  - op_signed=0, a=0xFFFFFFFF, b=2 → 0x00000001FFFFFFFE.
- Back-to-back: 1000 random operand pairs with random in_valid/out_ready gaps → every product matches the reference model, no lost or duplicated results.
